// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter:
// default widths and the outstanding-read owner encodings.
package imem_dmem_arbiter_pkg;

    // Machine-wide instruction and data widths.
    localparam int ISIZE = 16;
    localparam int DSIZE = 16;

    // Default arbiter widths follow the machine widths.
    localparam int ARB_ADDR_W = ISIZE;
    localparam int ARB_DATA_W = DSIZE;

    // Which requester owns the read whose data returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    // Counter width able to hold 0..max inclusive (at least 1 bit).
    function automatic int streak_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_arb_streak_counter.sv
// Saturating counter of consecutive data grants taken while fetch waits.
// Clear has priority over increment; the count sticks at MAX.
module arb_streak_counter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic saturated
);

    localparam int CW = streak_width(MAX);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          at_max;

    assign at_max    = (count_reg == CW'(MAX));
    assign saturated = at_max;

    // Next count: clear wins, otherwise count up until the ceiling.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && !at_max) begin
            count_next = count_reg + CW'(1);
        end
    end

    // Register the count; synchronous reset to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates the single shared memory between instruction fetch and the
// data port. Data wins contention (it is the older instruction) until it
// has taken MAX_DM_STREAK grants in a row while fetch waited, then fetch
// is forced through. Read data is steered back to the owner one cycle
// after its grant.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W        = ARB_ADDR_W,
    parameter int DATA_W        = ARB_DATA_W,
    parameter int MAX_DM_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_fetch
);

    // Requests are ignored for the whole cycle that reset is asserted.
    logic if_live;
    logic dm_live;
    logic streak_sat;
    owner_e owner_reg;

    assign if_live = if_req & ~rst;
    assign dm_live = dm_req & ~rst;

    // Grant selection: data first unless its streak has saturated.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (if_live && dm_live) begin
            if (streak_sat) begin
                if_gnt = 1'b1;
            end else begin
                dm_gnt = 1'b1;
            end
        end else if (if_live) begin
            if_gnt = 1'b1;
        end else if (dm_live) begin
            dm_gnt = 1'b1;
        end
    end

    assign stall_fetch = if_live & ~if_gnt;

    // Memory pin drive follows the winner; idle pins are held at zero.
    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_wen   = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    // Streak counts data wins only while fetch is actually waiting.
    arb_streak_counter #(
        .MAX (MAX_DM_STREAK)
    ) u_streak (
        .clk       (clk),
        .rst       (rst),
        .inc       (dm_gnt & if_live),
        .clr       (if_gnt | ~if_live),
        .saturated (streak_sat)
    );

    // Owner of the read returning next cycle; stores own nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= OWN_NONE;
        end else if (if_gnt) begin
            owner_reg <= OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            owner_reg <= OWN_DM;
        end else begin
            owner_reg <= OWN_NONE;
        end
    end

    // A read cut off by reset is dropped, so rvalid is masked by rst.
    assign if_rvalid = (owner_reg == OWN_IF) & ~rst;
    assign dm_rvalid = (owner_reg == OWN_DM) & ~rst;

    // Per-bit return steering; the non-owner sees zeros.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_ret
            assign if_rdata[gi] = mem_rdata[gi] & if_rvalid;
            assign dm_rdata[gi] = mem_rdata[gi] & dm_rvalid;
        end
    endgenerate

endmodule
